// File: rtl/gpr_read_unit.sv
// -----------------------------------------------------------------------------
// gpr_read_unit
//
// Read side of the SPARC general-purpose register bank. Takes the flattened
// Q outputs of the register array plus the write port currently driving that
// array, and serves two-operand read requests. Each accepted request produces
// one registered response one cycle later. Register 0 always reads as zero, a
// same-cycle write to the addressed register is bypassed to the reader, and
// addresses beyond the bank read as zero.
//
// Ports
//   Clk       system clock, rising edge
//   Clr       asynchronous active-high reset
//   RegQ      register array outputs, register i at RegQ[i*W +: W]
//   WrLe      write strobe into the bank this cycle
//   WrAddr    register being written this cycle
//   WrData    data being written this cycle
//   ReqValid  read request present
//   ReqReady  unit can take a request this cycle
//   RsA/RsB   operand register addresses
//   RspValid  RdA/RdB hold a response
//   RspReady  consumer takes the response this cycle
//   RdA/RdB   operand data
//   RspCount  responses consumed since reset, wraps at 2^CW
//
// Handshake: a transfer happens on a rising Clk edge where valid and ready
// are both 1. The producer holds valid and its payload steady until that
// edge; the consumer may change ready freely. ReqReady depends only on
// RspValid and RspReady, so a request can be taken on the same edge the
// previous response leaves, giving one request per cycle.
// -----------------------------------------------------------------------------
module gpr_read_unit #(
  parameter int NREG = 32,
  parameter int W    = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [NREG*W-1:0] RegQ,
  input  logic              WrLe,
  input  logic [AW-1:0]     WrAddr,
  input  logic [W-1:0]      WrData,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [AW-1:0]     RsA,
  input  logic [AW-1:0]     RsB,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [W-1:0]      RdA,
  output logic [W-1:0]      RdB,
  output logic [CW-1:0]     RspCount
);

  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rd_a_q, rd_a_d;
  logic [W-1:0]  rd_b_q, rd_b_d;
  logic [CW-1:0] rsp_count_q, rsp_count_d;

  logic          accept;
  logic          rsp_taken;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;

  // Operand select in priority order: r0, out-of-range, write bypass, array.
  // The array read is a compare-per-entry mux so no index can run past RegQ.
  function automatic logic [W-1:0] sel(
    input logic [AW-1:0]     a,
    input logic [NREG*W-1:0] regq,
    input logic              wr_le,
    input logic [AW-1:0]     wr_addr,
    input logic [W-1:0]      wr_data
  );
    logic [W-1:0] r;
    r = '0;
    if (a == '0) begin
      r = '0;
    end else if (32'(a) >= 32'(NREG)) begin
      r = '0;
    end else if (wr_le && (wr_addr == a)) begin
      r = wr_data;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (32'(a) == 32'(i)) begin
          r = regq[i*W +: W];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    ReqReady    = !rsp_valid_q || RspReady;
    accept      = ReqValid && ReqReady;
    rsp_taken   = rsp_valid_q && RspReady;

    sel_a       = sel(RsA, RegQ, WrLe, WrAddr, WrData);
    sel_b       = sel(RsB, RegQ, WrLe, WrAddr, WrData);

    rsp_valid_d = rsp_valid_q;
    rd_a_d      = rd_a_q;
    rd_b_d      = rd_b_q;

    // A new accept replaces the outgoing response on the same edge; a plain
    // take just drops valid and leaves the data registers as they were.
    if (accept) begin
      rsp_valid_d = 1'b1;
      rd_a_d      = sel_a;
      rd_b_d      = sel_b;
    end else if (rsp_taken) begin
      rsp_valid_d = 1'b0;
    end

    rsp_count_d = rsp_count_q + CW'(rsp_taken);
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      rsp_valid_q <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      rsp_count_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      rsp_count_q <= rsp_count_d;
    end
  end

  assign RspValid = rsp_valid_q;
  assign RdA      = rd_a_q;
  assign RdB      = rd_b_q;
  assign RspCount = rsp_count_q;

endmodule

// File: tb/tb_gpr_read_unit.sv
// -----------------------------------------------------------------------------
// tb_gpr_read_unit
//
// Directed bench for gpr_read_unit. Drivers push the hand-computed operand
// pair for every accepted request into exp_q; a negedge monitor pops and
// compares whenever a response is handed off, and tracks the expected
// response count. The counter is built 8 bits wide so the wrap is reachable
// in a few hundred cycles.
// -----------------------------------------------------------------------------
module tb_gpr_read_unit;

  localparam int NREG = 32;
  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int CW   = 8;

  logic              clk;
  logic              clr;
  logic [NREG*W-1:0] regq;
  logic              wr_le;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     rs_a;
  logic [AW-1:0]     rs_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rd_a;
  logic [W-1:0]      rd_b;
  logic [CW-1:0]     rsp_count;

  logic [2*W-1:0]    exp_q[$];
  logic [CW-1:0]     exp_cnt;
  int                n_cmp;
  int                n_bad;

  gpr_read_unit #(
    .NREG(NREG), .W(W), .AW(AW), .CW(CW)
  ) dut (
    .Clk     (clk),
    .Clr     (clr),
    .RegQ    (regq),
    .WrLe    (wr_le),
    .WrAddr  (wr_addr),
    .WrData  (wr_data),
    .ReqValid(req_valid),
    .ReqReady(req_ready),
    .RsA     (rs_a),
    .RsB     (rs_b),
    .RspValid(rsp_valid),
    .RspReady(rsp_ready),
    .RdA     (rd_a),
    .RdB     (rd_b),
    .RspCount(rsp_count)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic set_reg(input int r, input logic [W-1:0] v);
    regq[r*W +: W] = v;
  endtask

  // Called just after a rising edge. Presents a request, records the
  // expected pair once ReqReady is seen, and returns just after the accept
  // edge with ReqValid still high so calls can run back-to-back.
  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [W-1:0] ea, input logic [W-1:0] eb);
    bit got;
    got       = 1'b0;
    req_valid = 1'b1;
    rs_a      = a;
    rs_b      = b;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({ea, eb});
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("req_ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (clr) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      check("rsp_count", 64'(rsp_count), 64'(exp_cnt));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(exp_q.size()), 64'd1);
        end else begin
          check("rsp_data", {rd_a, rd_b}, exp_q.pop_front());
        end
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_cnt   = '0;
    clr       = 1'b1;
    regq      = '0;
    wr_le     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    req_valid = 1'b0;
    rs_a      = '0;
    rs_b      = '0;
    rsp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rd_a", 64'(rd_a), 64'd0);
    check("rst_rd_b", 64'(rd_b), 64'd0);
    check("rst_rsp_count", 64'(rsp_count), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    #8 clr = 1'b0;
    @(posedge clk);
    #1;

    // Basic read, latency one
    set_reg(5, 32'hAAAAAAAA);
    set_reg(9, 32'hABCDEF78);
    send(5, 9, 32'hAAAAAAAA, 32'hABCDEF78);
    check("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    idle();
    check("count_after_one", 64'(rsp_count), 64'd1);
    check("valid_drops", 64'(rsp_valid), 64'd0);
    check("data_kept_a", 64'(rd_a), 64'hAAAAAAAA);

    // r0 is zero even with a write to it and a nonzero array value
    set_reg(0, 32'hFFFFFFFF);
    wr_le   = 1'b1;
    wr_addr = 0;
    wr_data = 32'h12345678;
    send(0, 0, 32'h0, 32'h0);
    idle();

    // Bypass, then same write strobe on another register, then no strobe
    set_reg(7, 32'h11111111);
    wr_addr = 7;
    wr_data = 32'h77777777;
    send(7, 5, 32'h77777777, 32'hAAAAAAAA);
    send(5, 9, 32'hAAAAAAAA, 32'hABCDEF78);
    wr_le = 1'b0;
    send(7, 7, 32'h11111111, 32'h11111111);
    idle();

    // Stall: hold response while r9 is rewritten, requests must not enter
    rsp_ready = 1'b0;
    send(5, 9, 32'hAAAAAAAA, 32'hABCDEF78);
    for (int i = 0; i < 3; i++) begin
      set_reg(9, 32'hAAAAAAAA);
      wr_le     = 1'b1;
      wr_addr   = 9;
      wr_data   = 32'hAAAAAAAA;
      req_valid = 1'b1;
      rs_a      = 9;
      rs_b      = 9;
      @(negedge clk);
      check("stall_rd_b", 64'(rd_b), 64'hABCDEF78);
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    wr_le     = 1'b0;
    rsp_ready = 1'b1;
    send(9, 5, 32'hAAAAAAAA, 32'hAAAAAAAA);
    check("no_bubble", 64'(rsp_valid), 64'd1);
    send(9, 9, 32'hAAAAAAAA, 32'hAAAAAAAA);
    send(5, 0, 32'hAAAAAAAA, 32'h0);
    idle();

    // Counter wrap: clear, 2^CW-1 transfers, then one more
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 255; i++) send(9, 7, 32'hAAAAAAAA, 32'h11111111);
    idle();
    check("count_max", 64'(rsp_count), 64'hFF);
    send(7, 9, 32'h11111111, 32'hAAAAAAAA);
    idle();
    check("count_wrap", 64'(rsp_count), 64'd0);

    // Clear during a stall acts without a clock edge
    send(5, 5, 32'hAAAAAAAA, 32'hAAAAAAAA);
    idle();
    rsp_ready = 1'b0;
    send(7, 9, 32'h11111111, 32'hAAAAAAAA);
    idle();
    #2 clr = 1'b1;
    #1;
    check("clr_valid", 64'(rsp_valid), 64'd0);
    check("clr_rd_a", 64'(rd_a), 64'd0);
    check("clr_rd_b", 64'(rd_b), 64'd0);
    check("clr_count", 64'(rsp_count), 64'd0);
    check("clr_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    #1 clr = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    send(9, 5, 32'hAAAAAAAA, 32'hAAAAAAAA);
    idle();
    check("count_after_clr", 64'(rsp_count), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
